mult_share_arbiter: RTL and testbench

- Shares one instance of the team's 8x8 Wallace-tree multiplier among NREQ requesters.
- Round-robin arbitration, valid/ready handshake on both sides, two-stage registered pipeline (operand stage S1, product stage S2).
- Sits between the requesting datapath blocks and the combinational multiplier. Returns a 16-bit product tagged with the requester ID.

---
 rtl/mult_share_arbiter.sv | 117 +++++++++++
 tb/tb_mult_share_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier among NREQ requesters through a 2-stage pipeline.
// Define MSA_FIXED_PRIO_EN for fixed lowest-index-wins priority (removes the round-robin pointer).
module mult_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_prod,
  output logic [IDW-1:0]    resp_id,
  output logic              busy
);

  localparam logic [IDW:0] NReqW = (IDW+1)'(NREQ);

  logic           s1_vld;
  logic [7:0]     s1_a;
  logic [7:0]     s1_b;
  logic [IDW-1:0] s1_id;

  logic           out_free;
  logic           s1_adv;
  logic           s1_open;
  logic [IDW-1:0] start;
  logic [IDW-1:0] gnt;
  logic           gnt_vld;
  logic           accept;
  logic [IDW:0]   idx;
  logic [15:0]    prod;

`ifdef MSA_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] ptr;
  assign start = ptr;
`endif

  assign out_free = !resp_valid || resp_ready;
  assign s1_adv   = s1_vld && out_free;
  assign s1_open  = !s1_vld || s1_adv;
  assign busy     = s1_vld || resp_valid;

  // Search start, start+1, ... wrapping at NREQ; first pending requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, start} + (IDW+1)'(k);
      if (idx >= NReqW) begin
        idx = idx - NReqW;
      end
      if (!gnt_vld && req_valid[idx[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[IDW-1:0];
      end
    end
  end

  assign accept = rst_n && s1_open && gnt_vld;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt] = 1'b1;
    end
  end

  // Stand-in for the shared combinational multiplier; only prod[15:0] is consumed.
  assign prod = 16'(s1_a) * 16'(s1_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      resp_valid <= 1'b0;
      resp_prod  <= '0;
      resp_id    <= '0;
    end else begin
      if (accept) begin
        s1_a   <= req_a[gnt*8 +: 8];
        s1_b   <= req_b[gnt*8 +: 8];
        s1_id  <= gnt;
        s1_vld <= 1'b1;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end

      if (s1_adv) begin
        resp_prod  <= prod;
        resp_id    <= s1_id;
        resp_valid <= 1'b1;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifndef MSA_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: vector table, directed corner sequences and
// randomized traffic against an in-flight-queue reference model.
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [15:0]       resp_prod;
  logic [IDW-1:0]    resp_id;
  logic              busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_prod  (resp_prod),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  // In-flight operations, oldest first; in_s2 marks the one presented on the response port.
  typedef struct {
    int          id;
    logic [15:0] prod;
    bit          in_s2;
  } op_t;
  op_t q[$];
  int  m_ptr    = 0;
  bit  last_acc = 1'b0;
  int  last_gnt = -1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Checks the current cycle against the model, then applies the coming clock edge to it.
  function automatic void model_cycle();
    logic [NREQ-1:0] exp_rdy;
    bit              rv, s1occ, ofree, open;
    int              g, start, i;
    int unsigned     av, bv;
    op_t             n;
    exp_rdy = '0;
    g       = -1;
    if (!rst_n) begin
      chk("req_ready_in_reset", 32'(req_ready), 32'd0);
      q.delete();
      m_ptr    = 0;
      last_acc = 1'b0;
      last_gnt = -1;
      return;
    end
    rv = (q.size() > 0) && q[0].in_s2;
    chk("resp_valid", 32'(resp_valid), 32'(rv));
    if (rv) begin
      chk("resp_prod", 32'(resp_prod), 32'(q[0].prod));
      chk("resp_id", 32'(resp_id), 32'(q[0].id));
    end
    chk("busy", 32'(busy), 32'(q.size() > 0));
    s1occ = (q.size() > 0) && !q[q.size()-1].in_s2;
    ofree = !rv || resp_ready;
    open  = !s1occ || ofree;
`ifdef MSA_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    if (open) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (start + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (rv && resp_ready) void'(q.pop_front());
    if (s1occ && ofree) q[q.size()-1].in_s2 = 1'b1;
    if (g >= 0) begin
      av       = req_a[g*8 +: 8];
      bv       = req_b[g*8 +: 8];
      n.id     = g;
      n.prod   = 16'(av * bv);
      n.in_s2  = 1'b0;
      q.push_back(n);
      m_ptr = (g + 1) % NREQ;
    end
    last_acc = (g >= 0);
    last_gnt = g;
  endfunction

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [7:0] a, input logic [7:0] b);
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          r;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            vt[6];
    int              n;
    logic [NREQ-1:0] rr_exp[5];
    logic [15:0]     hold_prod;
    logic [IDW-1:0]  hold_id;

    vt[0] = '{r: 0, a: 8'hFF, b: 8'hFF, prod: 16'hFE01};
    vt[1] = '{r: 1, a: 8'h00, b: 8'hA5, prod: 16'h0000};
    vt[2] = '{r: 2, a: 8'h80, b: 8'h02, prod: 16'h0100};
    vt[3] = '{r: 3, a: 8'h01, b: 8'hFF, prod: 16'h00FF};
    vt[4] = '{r: 2, a: 8'h0C, b: 8'h0D, prod: 16'h009C};
    vt[5] = '{r: 1, a: 8'hFF, b: 8'h01, prod: 16'h00FF};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_prod", 32'(resp_prod), 32'd0);
    chk("reset_resp_id", 32'(resp_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Single isolated operations from the table.
    foreach (vt[v]) begin
      req_valid = '0;
      set_op(vt[v].r, vt[v].a, vt[v].b);
      req_valid[vt[v].r] = 1'b1;
      #1;
      chk("vec_same_cycle_ready", 32'(req_ready), 32'(1 << vt[v].r));
      n = 0;
      do begin
        step();
        n++;
      end while (!last_acc && n < 10);
      chk("vec_accepted", 32'(last_acc), 32'd1);
      req_valid = '0;
      n = 0;
      while (!resp_valid && n < 10) begin
        step();
        n++;
      end
      chk("vec_latency", 32'(n), 32'd1);
      chk("vec_prod", 32'(resp_prod), 32'(vt[v].prod));
      chk("vec_id", 32'(resp_id), 32'(vt[v].r));
      step();
      chk("vec_resp_drop", 32'(resp_valid), 32'd0);
      chk("vec_busy_drop", 32'(busy), 32'd0);
    end

`ifndef MSA_FIXED_PRIO_EN
    // Round-robin with all requesters pending.
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'h10);
    req_valid  = '1;
    resp_ready = 1'b1;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(rr_exp[k]));
      step();
      if (k >= 1) begin
        chk("rr_resp_valid", 32'(resp_valid), 32'd1);
        chk("rr_resp_id", 32'(resp_id), 32'(k - 1));
        chk("rr_resp_prod", 32'(resp_prod), 32'(16'h10 * k));
      end
    end

    // Backpressure: S2 holds id3, S1 holds id0.
    resp_ready = 1'b0;
    hold_prod  = resp_prod;
    hold_id    = resp_id;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_zero", 32'(req_ready), 32'd0);
      step();
      chk("bp_valid_held", 32'(resp_valid), 32'd1);
      chk("bp_prod_stable", 32'(resp_prod), 32'(hold_prod));
      chk("bp_id_stable", 32'(resp_id), 32'(hold_id));
    end
    resp_ready = 1'b1;
    step();
    chk("bp_resume_id", 32'(resp_id), 32'd0);
    chk("bp_resume_prod", 32'(resp_prod), 32'h0010);
    for (int k = 0; k < 4; k++) step();
`endif

    // Reset with two operations in flight.
    reset_dut();
    req_valid  = 4'b0001;
    set_op(0, 8'h33, 8'h03);
    resp_ready = 1'b0;
    step();
    step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = '0;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    req_valid = '1;
    #1;
    chk("midrst_ptr_zero", 32'(req_ready), 32'd1);
    req_valid  = 4'b0100;
    set_op(2, 8'h07, 8'h09);
    resp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    chk("midrst_new_valid", 32'(resp_valid), 32'd1);
    chk("midrst_new_id", 32'(resp_id), 32'd2);
    chk("midrst_new_prod", 32'(resp_prod), 32'h003F);
    step();

`ifdef MSA_FIXED_PRIO_EN
    reset_dut();
    set_op(0, 8'h02, 8'h03);
    set_op(2, 8'h04, 8'h05);
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fixed_grant0", 32'(req_ready), 32'd1);
      step();
    end
    req_valid = 4'b0100;
    #1;
    chk("fixed_grant2", 32'(req_ready), 32'd4);
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) step();
`endif

    // Randomized traffic; operands stay stable while a request is pending.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_op(i, 8'($urandom), 8'($urandom));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_acc) begin
        req_valid[last_gnt] = $urandom_range(0, 1) != 0;
        set_op(last_gnt, 8'($urandom), 8'($urandom));
      end
    end
    rst_n      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("drain_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
